// File: rtl/row_feeder_if.sv
// Stream, strobe and burst-read signals between the row feeder, its source and the scheduler.
interface row_feeder_if #(
  parameter int unsigned DW = 8
);
  logic          i_start;
  logic [DW-1:0] i_data;
  logic          i_dvalid;
  logic          o_ready;
  logic          o_vsync;
  logic          o_hsync;
  logic          i_rdreq;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_underflow;
  logic          o_frame_done;

  modport master (
    output i_start, i_data, i_dvalid, i_rdreq,
    input  o_ready, o_vsync, o_hsync, o_rdata, o_rvalid, o_underflow, o_frame_done
  );

  modport slave (
    input  i_start, i_data, i_dvalid, i_rdreq,
    output o_ready, o_vsync, o_hsync, o_rdata, o_rvalid, o_underflow, o_frame_done
  );
endinterface

// File: rtl/row_feeder.sv
// Ring of DEPTH row buffers between a raster source and the row scheduler.
// Frame phase (idle/fill/drain/done) is implied by rows_in/rows_out; no explicit FSM.
module row_feeder #(
  parameter int unsigned SIZE    = 56,
  parameter int unsigned CHANNEL = 64,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  row_feeder_if.slave  bus
);
  localparam int unsigned COL   = SIZE * CHANNEL;
  localparam int unsigned WORDS = DEPTH * COL;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW    = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned SW    = $clog2(DEPTH);
  localparam int unsigned OW    = $clog2(DEPTH + 1);
  localparam int unsigned RW    = $clog2(SIZE + 1);

  logic [DW-1:0] mem [WORDS];

  logic [SW-1:0] wr_slot, rd_slot;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [OW-1:0] occ;
  logic [RW-1:0] rows_in, rows_out;

  logic          wr_fire, rd_fire, wr_row_done, rd_row_done, clear;
  logic [AW-1:0] wr_addr, rd_addr;

  assign bus.o_ready = (occ < OW'(DEPTH)) && (rows_in < RW'(SIZE));
  assign clear       = i_rst || bus.i_start;
  assign wr_fire     = bus.i_dvalid && bus.o_ready;
  assign rd_fire     = bus.i_rdreq && (occ != '0);
  assign wr_row_done = wr_fire && (wr_cnt == CW'(COL - 1));
  assign rd_row_done = rd_fire && (rd_cnt == CW'(COL - 1));
  assign wr_addr     = AW'(AW'(wr_slot) * AW'(COL) + AW'(wr_cnt));
  assign rd_addr     = AW'(AW'(rd_slot) * AW'(COL) + AW'(rd_cnt));

  // Row storage; writes in the clear cycle belong to the discarded frame.
  always_ff @(posedge i_sclk) begin
    if (wr_fire && !clear) mem[wr_addr] <= bus.i_data;
  end

  always_ff @(posedge i_sclk) begin
    if (clear) begin
      wr_slot          <= '0;
      rd_slot          <= '0;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
      occ              <= '0;
      rows_in          <= '0;
      rows_out         <= '0;
      bus.o_vsync      <= !i_rst;
      bus.o_hsync      <= 1'b0;
      bus.o_rvalid     <= 1'b0;
      bus.o_rdata      <= '0;
      bus.o_underflow  <= 1'b0;
      bus.o_frame_done <= 1'b0;
    end else begin
      bus.o_vsync      <= 1'b0;
      bus.o_hsync      <= wr_row_done;
      bus.o_rvalid     <= rd_fire;
      bus.o_frame_done <= rd_row_done && (rows_out == RW'(SIZE - 1));
      if (bus.i_rdreq && (occ == '0)) bus.o_underflow <= 1'b1;

      if (wr_fire) begin
        if (wr_row_done) begin
          wr_cnt  <= '0;
          wr_slot <= (wr_slot == SW'(DEPTH - 1)) ? '0 : wr_slot + SW'(1);
          rows_in <= rows_in + RW'(1);
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end

      if (rd_fire) begin
        bus.o_rdata <= mem[rd_addr];
        if (rd_row_done) begin
          rd_cnt   <= '0;
          rd_slot  <= (rd_slot == SW'(DEPTH - 1)) ? '0 : rd_slot + SW'(1);
          rows_out <= rows_out + RW'(1);
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end

      // Simultaneous row fill and row release leave occupancy unchanged.
      unique case ({wr_row_done, rd_row_done})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_row_feeder.sv
// Directed bench for row_feeder with SIZE=4, CHANNEL=2, DEPTH=2 (8 words per row).
module tb_row_feeder;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  row_feeder_if #(.DW(DW)) bus ();

  row_feeder #(.SIZE(4), .CHANNEL(2), .DW(DW), .DEPTH(2)) dut (
    .i_sclk (clk),
    .i_rst  (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        start;
    logic        dv;
    logic        rd;
    logic [7:0]  data;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {ready, vsync, hsync, rvalid, underflow, frame_done, rdata}
  function automatic logic [13:0] e(input logic r, v, h, rv, u, f, input logic [7:0] d);
    return {r, v, h, rv, u, f, d};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.o_ready, bus.o_vsync, bus.o_hsync, bus.o_rvalid,
            bus.o_underflow, bus.o_frame_done, bus.o_rdata};
  endfunction

  function automatic vec_t mk(input logic st, dv, rd, input logic [7:0] d, input logic [13:0] x);
    vec_t v;
    v.start = st; v.dv = dv; v.rd = rd; v.data = d; v.exp = x;
    return v;
  endfunction

  task automatic drv(input logic st, dv, rd, input logic [7:0] d);
    bus.i_start  = st;
    bus.i_dvalid = dv;
    bus.i_rdreq  = rd;
    bus.i_data   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int hs, fd;

  initial begin
    // Basic table: start, one row in, one row out, underflow, start clears it
    vecs.push_back(mk(1, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, 8'(k), e(1, 0, (k == 7), 0, 0, 0, 0)));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 1, 0, e(1, 0, 0, 1, 0, 0, 8'(k))));
    vecs.push_back(mk(0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 7)));
    vecs.push_back(mk(0, 0, 1, 0, e(1, 0, 0, 0, 1, 0, 7)));
    vecs.push_back(mk(0, 0, 0, 0, e(1, 0, 0, 0, 1, 0, 7)));
    vecs.push_back(mk(1, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0)));

    // Reset with coincident start: reset wins, no vsync
    drv(1, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_wins_outs", 32'(outs()), 32'(e(1, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    drv(0, 0, 0, 0);
    tick();
    chk("reset_outs", 32'(outs()), 32'(e(1, 0, 0, 0, 0, 0, 0)));
    chk("reset_occ", 32'(dut.occ), 0);

    foreach (vecs[i]) begin
      drv(vecs[i].start, vecs[i].dv, vecs[i].rd, vecs[i].data);
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    drv(0, 0, 0, 0);
    tick();
    chk("post_table_vsync", 32'(bus.o_vsync), 0);
    chk("underflow_rdcnt", 32'(dut.rd_cnt), 0);

    // Full: two rows without reads, then a rejected word
    drv(1, 0, 0, 0); tick();
    for (int k = 0; k < 16; k++) begin
      drv(0, 1, 0, 8'(k)); tick();
      chk($sformatf("full_ready%0d", k), 32'(bus.o_ready), (k == 15) ? 0 : 1);
    end
    chk("full_hsync", 32'(bus.o_hsync), 1);
    for (int k = 0; k < 3; k++) begin
      drv(0, 1, 0, 8'hAA); tick();
      chk("full_ready_held", 32'(bus.o_ready), 0);
    end
    chk("full_occ", 32'(dut.occ), 2);
    for (int k = 0; k < 16; k++) begin
      drv(0, 0, 1, 0); tick();
      chk($sformatf("full_rd%0d", k), 32'({bus.o_rvalid, bus.o_rdata}), 32'({1'b1, 8'(k)}));
    end
    chk("full_drained_ready", 32'({bus.o_ready, dut.occ}), 32'({1'b1, 2'd0}));

    // Row fill and row release in the same cycle with occ=1
    drv(1, 0, 0, 0); tick();
    for (int k = 0; k < 8; k++) begin
      drv(0, 1, 0, 8'(k)); tick();
    end
    chk("same_pre_occ", 32'(dut.occ), 1);
    for (int k = 0; k < 8; k++) begin
      drv(0, 1, 1, 8'(100 + k)); tick();
      chk($sformatf("same_rd%0d", k), 32'(bus.o_rdata), k);
      chk($sformatf("same_occ_ready%0d", k), 32'({bus.o_ready, dut.occ}), 32'({1'b1, 2'd1}));
    end
    chk("same_hsync", 32'(bus.o_hsync), 1);
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, 0); tick();
      chk($sformatf("same_row1_%0d", k), 32'(bus.o_rdata), 100 + k);
    end
    chk("same_end_occ", 32'(dut.occ), 0);

    // Full frame: four rows written and read back
    drv(1, 0, 0, 0); tick();
    hs = 0;
    fd = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        drv(0, 1, 0, 8'(r * 8 + k)); tick();
        if (bus.o_hsync) hs++;
      end
      for (int k = 0; k < 8; k++) begin
        drv(0, 0, 1, 0); tick();
        if (bus.o_frame_done) fd++;
        if (bus.o_hsync) hs++;
        chk($sformatf("frame_rd%0d_%0d", r, k), 32'({bus.o_frame_done, bus.o_rdata}),
            32'({(r == 3 && k == 7), 8'(r * 8 + k)}));
      end
    end
    drv(0, 1, 0, 8'h55); tick();
    if (bus.o_frame_done) fd++;
    chk("frame_hsync_count", hs, 4);
    chk("frame_done_count", fd, 1);
    chk("frame_end_ready", 32'(bus.o_ready), 0);
    chk("frame_end_rowsin", 32'(dut.rows_in), 4);
    drv(0, 0, 1, 0); tick();
    chk("frame_end_underflow", 32'({bus.o_underflow, bus.o_rvalid}), 32'(2'b10));

    // Abort mid-row-2, then a clean row shows old data discarded
    drv(1, 0, 0, 0); tick();
    for (int k = 0; k < 16; k++) begin
      drv(0, 1, 0, 8'(k)); tick();
    end
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, 0); tick();
    end
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 0, 8'(50 + k)); tick();
    end
    chk("abort_pre", 32'({dut.rows_in, dut.wr_cnt, dut.occ}), 32'({3'd2, 3'd4, 2'd1}));
    drv(1, 0, 0, 0); tick();
    chk("abort_vsync", 32'(bus.o_vsync), 1);
    chk("abort_state", 32'({dut.wr_slot, dut.rd_slot, dut.wr_cnt, dut.rd_cnt,
                            dut.occ, dut.rows_in, dut.rows_out}), 0);
    for (int k = 0; k < 8; k++) begin
      drv(0, 1, 0, 8'(200 + k)); tick();
      if (k == 0) chk("abort_vsync_one", 32'(bus.o_vsync), 0);
    end
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, 0); tick();
      chk($sformatf("abort_rd%0d", k), 32'(bus.o_rdata), 200 + k);
    end

    drv(0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/row_feeder.md
Name: row_feeder

Overview:
- Upstream stage of the row-scheduling pipeline. Accepts a raster stream of feature-map words in row order (SIZE*CHANNEL words per row) and stores them in a ring of row buffers.
- Produces the frame/row strobes (o_vsync, o_hsync) that drive the scheduler's i_vsync/i_hsync.
- Returns stored words on the scheduler's burst read requests with 1-cycle latency, aligned with the scheduler's o_valid.
- Applies backpressure to the source when all row slots are occupied.

Parameters:
- SIZE, 56, rows per frame and words per read burst.
- CHANNEL, 64, bursts per row; one row = COL = SIZE*CHANNEL words.
- DW, 8, data word width.
- DEPTH, 4, number of row slots in the ring buffer (>=2).

Ports:
- i_sclk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  frame-start pulse; synchronous clear of all frame state.
- i_data  in  DW  input word.
- i_dvalid  in  1  input word valid.
- o_ready  out  1  word accepted this cycle when i_dvalid && o_ready.
- o_vsync  out  1  one-cycle frame-start strobe to scheduler.
- o_hsync  out  1  one-cycle strobe: one more complete row is readable.
- i_rdreq  in  1  scheduler read request, one word per cycle.
- o_rdata  out  DW  read word, valid the cycle after the i_rdreq cycle.
- o_rvalid  out  1  registered copy of an accepted i_rdreq.
- o_underflow  out  1  sticky: i_rdreq seen with no readable row.
- o_frame_done  out  1  one-cycle pulse when row SIZE has been fully read.

Behaviour:
- Storage: simple dual-port RAM of DEPTH*COL words, registered read, 1-cycle read latency. Write row w occupies addresses w*COL..w*COL+COL-1. Read and write never target the same slot, so read-during-write is undefined-free.
- Registers:
  - wr_slot, rd_slot: 0..DEPTH-1, wrap.
  - wr_cnt, rd_cnt: 0..COL-1.
  - occ: 0..DEPTH, rows written and not yet fully read.
  - rows_in, rows_out: 0..SIZE.
- Reset (i_rst): all registers 0. o_vsync, o_hsync, o_rvalid, o_underflow and o_frame_done are 0. o_rdata is 0.
- i_start (without i_rst): same clear as reset; o_vsync=1 the next cycle. Aborts any frame in progress, and data from that frame is discarded.
- Priority when i_rst and i_start coincide: i_rst wins and o_vsync stays 0.
- o_ready = (occ<DEPTH) && (rows_in<SIZE). Combinational from registers only; no dependence on i_dvalid.
- Write: on an accepted word, write the RAM at wr_slot*COL+wr_cnt and increment wr_cnt. At wr_cnt==COL-1:
  - wr_cnt←0, wr_slot advances with wrap;
  - rows_in++, occ++;
  - o_hsync=1 in the following cycle.
- Read: on i_rdreq with occ>0, issue a RAM read at rd_slot*COL+rd_cnt and set o_rvalid=1 next cycle. At rd_cnt==COL-1:
  - rd_cnt←0, rd_slot advances with wrap;
  - occ--, rows_out++;
  - when rows_out reaches SIZE, o_frame_done=1 the next cycle.
- Underflow: i_rdreq with occ==0 sets o_underflow. Counters do not advance, o_rvalid stays 0 and o_rdata holds its value. The flag is cleared only by reset or i_start.
- Row completion and row release in the same cycle: occ is unchanged and o_ready does not glitch low.
- Full: occ==DEPTH forces o_ready=0 and no write occurs, even if i_dvalid=1.
- End of frame: after rows_in==SIZE, o_ready stays low until i_start or reset. Further i_dvalid is ignored.
- i_rdreq after rows_out==SIZE counts as underflow.
- No other state machine states. Frame phases are derived from rows_in/rows_out: IDLE (after reset), FILL, DRAIN, DONE.

Test Plan:
- Use SIZE=4, CHANNEL=2, DEPTH=2, COL=8 unless noted.
- Reset then i_start → o_vsync=1 for exactly 1 cycle; o_ready=1; occ=0.
- Stream 8 words 0..7 with continuous i_dvalid → o_hsync pulses once, 1 cycle after the 8th accept. Then 8 i_rdreq cycles → o_rdata 0..7 on consecutive cycles, each 1 cycle after its request; occ returns to 0.
- Stream 16 words without reads → o_ready drops after the 16th accept and stays low through further i_dvalid. A word offered then is not stored: the read-back of rows 0-1 gives exactly words 0..15.
- Drive the 8th write of a row and the 8th read of another row in the same cycle, with occ=1 → occ stays 1 and o_ready stays 1 throughout.
- i_rdreq with occ=0 → o_underflow=1, o_rvalid=0, rd_cnt unchanged. A subsequent i_start clears o_underflow.
- Full frame of 32 words interleaved with 32 reads → 4 o_hsync pulses, one o_frame_done pulse after the 32nd read, then o_ready=0. Asserting i_start mid-row-2 instead → all counters cleared and o_vsync pulses.
